// File: rtl/skew_addr_gen_pkg.sv
// Shared FSM encoding and sweep-length helper for the skewed SRAM address generator.
// No logic of its own; imported by skew_addr_gen and skew_lane_dec.
package skew_addr_gen_pkg;

    localparam logic [1:0] ENC_IDLE = 2'b00;
    localparam logic [1:0] ENC_RUN  = 2'b01;
    localparam logic [1:0] ENC_FIN  = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = ENC_IDLE,
        ST_RUN  = ENC_RUN,
        ST_FIN  = ENC_FIN
    } state_t;

    // Index of the final step: the last lane starts NUM_LANES-1 steps late
    // and then needs k_len steps.
    function automatic int calc_last(input int k_len, input int num_lanes);
        return k_len + num_lanes - 2;
    endfunction

endpackage

// File: rtl/skew_lane_dec.sv
// Per-lane decode: offset = step - LANE; valid when 0 <= offset < k_len.
// Purely combinational; addresses are base + offset, wrapping mod 2^ADDR_W.
module skew_lane_dec
    import skew_addr_gen_pkg::*;
#(
    parameter int LANE   = 0,
    parameter int ADDR_W = 10,
    parameter int LEN_W  = 7
) (
    input  logic [LEN_W:0]    step,
    input  logic [LEN_W-1:0]  k_len,
    input  logic [ADDR_W-1:0] w_base,
    input  logic [ADDR_W-1:0] d_base,
    output logic              vld,
    output logic [ADDR_W-1:0] w_addr,
    output logic [ADDR_W-1:0] d_addr
);

    localparam int STEP_W = LEN_W + 1;

    logic signed [STEP_W:0] off;
    logic                   in_range;

    always_comb begin
        off      = $signed({1'b0, step}) - $signed((STEP_W + 1)'(LANE));
        in_range = !off[STEP_W] && (off[STEP_W-1:0] < {1'b0, k_len});
        vld      = in_range;
        w_addr   = '0;
        d_addr   = '0;
        if (in_range) begin
            w_addr = w_base + ADDR_W'(off[STEP_W-1:0]);
            d_addr = d_base + ADDR_W'(off[STEP_W-1:0]);
        end
    end

endmodule

// File: rtl/skew_addr_gen.sv
// Diagonally skewed weight/data SRAM read-address sequencer; outputs lag the step counter by one cycle.
// Optional stall input under SKEW_ADDR_GEN_STALL_EN freezes a running sweep and defers done.
module skew_addr_gen
    import skew_addr_gen_pkg::*;
#(
    parameter int NUM_LANES = 32,
    parameter int ADDR_W    = 10,
    parameter int LEN_W     = 7
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        start,
`ifdef SKEW_ADDR_GEN_STALL_EN
    input  logic                        stall,
`endif
    input  logic [LEN_W-1:0]            k_len,
    input  logic [ADDR_W-1:0]           w_base,
    input  logic [ADDR_W-1:0]           d_base,
    output logic                        busy,
    output logic                        done,
    output logic [LEN_W:0]              step_num,
    output logic [NUM_LANES*ADDR_W-1:0] sram_raddr_w,
    output logic [NUM_LANES*ADDR_W-1:0] sram_raddr_d,
    output logic [NUM_LANES-1:0]        lane_vld
);

    localparam int STEP_W = LEN_W + 1;

    state_t                      state;
    logic [STEP_W-1:0]           step_q;
    logic [STEP_W-1:0]           last;
    logic [LEN_W-1:0]            k_len_q;
    logic [ADDR_W-1:0]           w_base_q;
    logic [ADDR_W-1:0]           d_base_q;
    logic                        done_q;
    logic                        freeze;
    logic [NUM_LANES-1:0]        dec_vld;
    logic [NUM_LANES*ADDR_W-1:0] dec_w;
    logic [NUM_LANES*ADDR_W-1:0] dec_d;

`ifdef SKEW_ADDR_GEN_STALL_EN
    // busy is only set for real sweeps, so stall is inert in IDLE and in the zero-length FIN.
    assign freeze = stall && busy;
`else
    assign freeze = 1'b0;
`endif

    assign last = STEP_W'(calc_last(int'(k_len_q), NUM_LANES));
    assign done = done_q && !freeze;

    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        skew_lane_dec #(
            .LANE   (i),
            .ADDR_W (ADDR_W),
            .LEN_W  (LEN_W)
        ) u_lane (
            .step   (step_q),
            .k_len  (k_len_q),
            .w_base (w_base_q),
            .d_base (d_base_q),
            .vld    (dec_vld[i]),
            .w_addr (dec_w[i*ADDR_W +: ADDR_W]),
            .d_addr (dec_d[i*ADDR_W +: ADDR_W])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            step_q   <= '0;
            k_len_q  <= '0;
            w_base_q <= '0;
            d_base_q <= '0;
            busy     <= 1'b0;
            done_q   <= 1'b0;
        end else if (!freeze) begin
            done_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        k_len_q  <= k_len;
                        w_base_q <= w_base;
                        d_base_q <= d_base;
                        step_q   <= '0;
                        done_q   <= 1'b1;
                        state    <= ST_FIN;
                        if (k_len != '0) begin
                            done_q <= 1'b0;
                            busy   <= 1'b1;
                            state  <= ST_RUN;
                        end
                    end
                end
                ST_RUN: begin
                    if (step_q == last) begin
                        done_q <= 1'b1;
                        state  <= ST_FIN;
                    end else begin
                        step_q <= step_q + 1'b1;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Output stage presents the step decoded in the previous cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            step_num     <= '0;
            lane_vld     <= '0;
            sram_raddr_w <= '0;
            sram_raddr_d <= '0;
        end else if (!freeze) begin
            if (state == ST_RUN) begin
                step_num     <= step_q;
                lane_vld     <= dec_vld;
                sram_raddr_w <= dec_w;
                sram_raddr_d <= dec_d;
            end else begin
                step_num     <= '0;
                lane_vld     <= '0;
                sram_raddr_w <= '0;
                sram_raddr_d <= '0;
            end
        end
    end

endmodule

// File: tb/tb_skew_addr_gen.sv
// Randomized bench for skew_addr_gen against a per-cycle behavioural model of the sweep timeline.
// Stall scenarios are exercised when SKEW_ADDR_GEN_STALL_EN is defined.
module tb_skew_addr_gen;

    localparam int NL = 4;
    localparam int AW = 10;
    localparam int LW = 7;

    logic             clk;
    logic             rst_n;
    logic             start;
`ifdef SKEW_ADDR_GEN_STALL_EN
    logic             stall;
`endif
    logic [LW-1:0]    k_len;
    logic [AW-1:0]    w_base;
    logic [AW-1:0]    d_base;
    logic             busy;
    logic             done;
    logic [LW:0]      step_num;
    logic [NL*AW-1:0] sram_raddr_w;
    logic [NL*AW-1:0] sram_raddr_d;
    logic [NL-1:0]    lane_vld;

    int n_chk  = 0;
    int n_pass = 0;
    int cur_e  = 0;

    typedef struct packed {
        logic             busy;
        logic             done;
        logic [LW:0]      step;
        logic [NL-1:0]    vld;
        logic [NL*AW-1:0] w;
        logic [NL*AW-1:0] d;
    } exp_t;

    skew_addr_gen #(
        .NUM_LANES (NL),
        .ADDR_W    (AW),
        .LEN_W     (LW)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
`ifdef SKEW_ADDR_GEN_STALL_EN
        .stall        (stall),
`endif
        .k_len        (k_len),
        .w_base       (w_base),
        .d_base       (d_base),
        .busy         (busy),
        .done         (done),
        .step_num     (step_num),
        .sram_raddr_w (sram_raddr_w),
        .sram_raddr_d (sram_raddr_d),
        .lane_vld     (lane_vld)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s (e=%0d): got %0h expected %0h", tag, cur_e, obs, exp);
    endtask

    // Expected outputs e cycles after the accepting edge (cycle 0 = start sampled).
    function automatic exp_t model(input int k, input int wb, input int db, input int e, input bit stalled);
        exp_t x;
        int   last;
        int   s;
        int   off;
        x    = '0;
        last = k + NL - 2;
        s    = e - 2;
        if (k == 0) begin
            x.done = (e == 1);
            return x;
        end
        x.busy = (e >= 1) && (e <= 2 + last);
        x.done = (e == 2 + last) && !stalled;
        if (s >= 0 && s <= last) begin
            x.step = s[LW:0];
            for (int i = 0; i < NL; i++) begin
                off = s - i;
                if (off >= 0 && off < k) begin
                    x.vld[i]        = 1'b1;
                    x.w[i*AW +: AW] = AW'(wb + off);
                    x.d[i*AW +: AW] = AW'(db + off);
                end
            end
        end
        return x;
    endfunction

    task automatic check_out(input exp_t x);
        chk("busy", 64'(busy), 64'(x.busy));
        chk("done", 64'(done), 64'(x.done));
        chk("step_num", 64'(step_num), 64'(x.step));
        chk("lane_vld", 64'(lane_vld), 64'(x.vld));
        chk("raddr_w", 64'(sram_raddr_w), 64'(x.w));
        chk("raddr_d", 64'(sram_raddr_d), 64'(x.d));
    endtask

    // Called at posedge+1; returns at posedge+1 of an IDLE cycle (or of the
    // accepting cycle of the next sweep when hold keeps start high).
    task automatic sweep(input int k, input int wb, input int db, input bit hold,
                         input int abort_e, input int stall_e, input int stall_n, input bit rnd_stall);
        int   e;
        int   guard;
        int   end_e;
        int   stall_left;
        bit   st;
        exp_t x;
        e          = 1;
        guard      = 0;
        stall_left = stall_n;
        end_e      = (k == 0) ? 1 : k + NL;
        start  = 1'b1;
        k_len  = LW'(k);
        w_base = AW'(wb);
        d_base = AW'(db);
`ifdef SKEW_ADDR_GEN_STALL_EN
        stall = 1'b0;
`endif
        @(posedge clk); #1;
        while (e <= end_e) begin
            if (guard == 600) break;
            guard++;
            cur_e  = e;
            start  = hold;
            k_len  = LW'($urandom_range(127));
            w_base = AW'($urandom_range(1023));
            d_base = AW'($urandom_range(1023));
            st = 1'b0;
            if (e == stall_e && stall_left > 0) begin
                st = 1'b1;
                stall_left--;
            end else if (rnd_stall && $urandom_range(3) == 0) begin
                st = 1'b1;
            end
`ifdef SKEW_ADDR_GEN_STALL_EN
            stall = st;
`else
            st = 1'b0;
`endif
            x = model(k, wb, db, e, st);
            if (e == abort_e) begin
                rst_n = 1'b0;
                #2;
                check_out('0);
                @(posedge clk); #1;
                rst_n = 1'b1;
                start = 1'b0;
`ifdef SKEW_ADDR_GEN_STALL_EN
                stall = 1'b0;
`endif
                return;
            end
            @(negedge clk);
            check_out(x);
            @(posedge clk); #1;
            if (!(st && x.busy)) e++;
        end
        chk("sweep_bounded", 64'(guard < 600), 64'd1);
`ifdef SKEW_ADDR_GEN_STALL_EN
        stall = 1'b0;
`endif
        if (!hold) begin
            cur_e = end_e + 1;
            start = 1'b0;
`ifdef SKEW_ADDR_GEN_STALL_EN
            stall = 1'($urandom_range(1));
`endif
            @(negedge clk);
            check_out('0);
            @(posedge clk); #1;
        end
    endtask

    initial begin
        rst_n  = 1'b0;
        start  = 1'b0;
        k_len  = '0;
        w_base = '0;
        d_base = '0;
`ifdef SKEW_ADDR_GEN_STALL_EN
        stall  = 1'b0;
`endif
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_out('0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        sweep(3, 'h100, 'h200, 1'b0, -1, -1, 0, 1'b0);
        sweep(4, 'h3FE, 'h3FD, 1'b0, -1, -1, 0, 1'b0);
        sweep(0, 'h055, 'h0AA, 1'b0, -1, -1, 0, 1'b0);
        sweep(5, 'h010, 'h020, 1'b1, -1, -1, 0, 1'b0);
        sweep(2, 'h3FF, 'h001, 1'b1, -1, -1, 0, 1'b0);
        sweep(0, 'h123, 'h321, 1'b1, -1, -1, 0, 1'b0);
        sweep(3, 'h200, 'h300, 1'b0, -1, -1, 0, 1'b0);
        sweep(5, 'h040, 'h080, 1'b0, 5, -1, 0, 1'b0);
        sweep(3, 'h100, 'h200, 1'b0, -1, -1, 0, 1'b0);
        sweep(127, 'h3C0, 'h000, 1'b0, -1, -1, 0, 1'b0);
`ifdef SKEW_ADDR_GEN_STALL_EN
        sweep(3, 'h100, 'h200, 1'b0, -1, 3, 2, 1'b0);
        sweep(3, 'h100, 'h200, 1'b0, -1, 7, 2, 1'b0);
        sweep(6, 'h311, 'h022, 1'b0, -1, 1, 3, 1'b0);
`endif
        for (int n = 0; n < 16; n++) begin
            sweep($urandom_range(12), $urandom_range(1023), $urandom_range(1023),
                  1'($urandom_range(1)), -1, -1, 0, 1'($urandom_range(1)));
        end
        start = 1'b0;
        sweep(2, 'h001, 'h002, 1'b0, -1, -1, 0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
